// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: load-use stalls,
// taken-branch flushes, data-memory wait freezes with timeout, and perf counters.
`ifndef ASIZE
`define ASIZE 5
`endif

module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`ASIZE-1:0] id_rs,
    input  logic [`ASIZE-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_memread,
    input  logic              ex_wen,
    input  logic [`ASIZE-1:0] ex_waddr,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_bubble,
    output logic              exmem_en,
    output logic              mem_err,
    output logic [1:0]        hazard_state,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_t;

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
    logic                mem_err_next;
    logic                mem_wait;
    logic                load_use;

    assign mem_wait = mem_req & ~mem_ready;
    assign load_use = ex_memread & ex_wen & (ex_waddr != '0) &
                      ((id_use_rs & (id_rs == ex_waddr)) |
                       (id_use_rt & (id_rt == ex_waddr)));
    assign hazard_state = state;

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        // Freeze outranks branch, so a held branch fires only on the release cycle.
        if (rst || state == ERR || mem_wait) begin
            pc_en = 1'b0;
        end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_err_next  = mem_err;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next   = ERR;
                    mem_err_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_W'(1);
                end
            end
            ERR: begin
                mem_err_next = 1'b1;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            mem_err  <= mem_err_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_en && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
            if (ifid_flush && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked against
// a streak-based reference model; a second instance with 4-bit counters checks saturation.
`ifndef ASIZE
`define ASIZE 5
`endif

module tb_hazard_ctrl;

    localparam int MT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [`ASIZE-1:0] id_rs, id_rt, ex_waddr;
    logic id_use_rs, id_use_rt, ex_memread, ex_wen, ex_branch_taken, mem_req, mem_ready;

    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, mem_err;
    logic [1:0] hazard_state;
    logic [15:0] stall_count, flush_count;

    logic b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en, b_mem_err;
    logic [1:0] b_hazard_state;
    logic [3:0] b_stall_count, b_flush_count;

    int tests = 0;
    int fails = 0;

    // Reference model: consecutive wait cycles, sticky error, saturating counts
    int m_streak, m_stall, m_flush, m_stall4, m_flush4;
    bit m_err;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
        .exmem_en(exmem_en), .mem_err(mem_err), .hazard_state(hazard_state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memread(ex_memread),
        .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
        .ifid_flush(b_ifid_flush), .idex_en(b_idex_en), .idex_bubble(b_idex_bubble),
        .exmem_en(b_exmem_en), .mem_err(b_mem_err), .hazard_state(b_hazard_state),
        .stall_count(b_stall_count), .flush_count(b_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_waddr = '0;
        id_use_rs = 0; id_use_rt = 0; ex_memread = 0; ex_wen = 0;
        ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    // Called at a negedge with inputs applied; checks, then advances one clock.
    task automatic cycle(input string tag);
        logic lu, frz;
        logic [5:0] e;
        logic [1:0] st;
        #1;
        lu = ex_memread && ex_wen && (ex_waddr != 0) &&
             ((id_use_rs && id_rs == ex_waddr) || (id_use_rt && id_rt == ex_waddr));
        frz = m_err || (mem_req && !mem_ready);
        // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble}
        if (frz)                  e = 6'b000000;
        else if (ex_branch_taken) e = 6'b111111;
        else if (lu)              e = 6'b001101;
        else                      e = 6'b111100;
        st = m_err ? 2'b10 : (m_streak > 0 ? 2'b01 : 2'b00);
        chk({tag, ".ctl"}, 32'({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble}), 32'(e));
        chk({tag, ".ctl4"}, 32'({b_pc_en, b_ifid_en, b_idex_en, b_exmem_en, b_ifid_flush, b_idex_bubble}), 32'(e));
        chk({tag, ".state"}, 32'(hazard_state), 32'(st));
        chk({tag, ".state4"}, 32'(b_hazard_state), 32'(st));
        chk({tag, ".err"}, 32'(mem_err), 32'(m_err));
        chk({tag, ".stall"}, 32'(stall_count), m_stall);
        chk({tag, ".flush"}, 32'(flush_count), m_flush);
        chk({tag, ".stall4"}, 32'(b_stall_count), m_stall4);
        chk({tag, ".flush4"}, 32'(b_flush_count), m_flush4);
        @(posedge clk);
        if (!e[5]) begin m_stall = sat(m_stall, 65535); m_stall4 = sat(m_stall4, 15); end
        if (e[1])  begin m_flush = sat(m_flush, 65535); m_flush4 = sat(m_flush4, 15); end
        if (!m_err) begin
            if (mem_req && !mem_ready) begin
                m_streak++;
                if (m_streak == MT) m_err = 1;
            end else begin
                m_streak = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; effects must be visible before any edge.
    task automatic do_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        chk({tag, ".ctl"}, 32'({pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble}), 0);
        chk({tag, ".state"}, 32'(hazard_state), 0);
        chk({tag, ".err"}, 32'(mem_err), 0);
        chk({tag, ".cnt"}, 32'({stall_count, flush_count}), 0);
        chk({tag, ".cnt4"}, 32'({b_stall_count, b_flush_count, b_hazard_state, b_mem_err}), 0);
        m_streak = 0; m_err = 0; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_wen = 1; ex_waddr = 5; id_rs = 5; id_use_rs = 1;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset("init");

        // Load-use stall, then non-hazard variants
        set_load_use();
        cycle("lu");
        chk("lu.stall_cnt", 32'(stall_count), 1);
        ex_waddr = 0; id_rs = 0;
        cycle("lu_r0");
        idle(); set_load_use(); id_use_rs = 0;
        cycle("lu_nouse");
        idle(); set_load_use(); id_rs = 3; id_rt = 5; id_use_rt = 1;
        cycle("lu_rt");
        chk("lu_rt.stall_cnt", 32'(stall_count), 2);

        // Branch beats load-use
        do_reset("rst_br");
        set_load_use(); ex_branch_taken = 1;
        cycle("br_lu");
        chk("br_lu.flush_cnt", 32'(flush_count), 1);
        chk("br_lu.stall_cnt", 32'(stall_count), 0);

        // Three-cycle memory wait
        idle(); do_reset("rst_mw");
        mem_req = 1;
        repeat (3) cycle("mw");
        mem_ready = 1;
        cycle("mw_rdy");
        chk("mw.state_after", 32'(hazard_state), 0);
        chk("mw.stall_cnt", 32'(stall_count), 3);

        // Branch held through a two-cycle wait fires once
        idle(); do_reset("rst_mwb");
        mem_req = 1; ex_branch_taken = 1;
        repeat (2) cycle("mwb");
        mem_ready = 1;
        cycle("mwb_rdy");
        idle();
        cycle("mwb_after");
        chk("mwb.flush_cnt", 32'(flush_count), 1);

        // Never-ready access times out into ERR
        do_reset("rst_to");
        mem_req = 1;
        repeat (MT) cycle("to");
        chk("to.state", 32'(hazard_state), 2);
        chk("to.err", 32'(mem_err), 1);
        idle();
        repeat (2) cycle("to_err");
        do_reset("to_rst");

        // Counter saturation on the 4-bit instance
        set_load_use();
        repeat (20) cycle("sat");
        chk("sat.stall4", 32'(b_stall_count), 15);
        chk("sat.stall16", 32'(stall_count), 20);

        // Randomized traffic
        idle(); do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            if ((m_err && $urandom_range(0, 3) == 0) ||
                (m_streak > 0 && $urandom_range(0, 24) == 0)) begin
                do_reset("rand_rst");
            end
            id_rs = `ASIZE'($urandom_range(0, 3));
            id_rt = `ASIZE'($urandom_range(0, 3));
            ex_waddr = `ASIZE'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1));
            id_use_rt = 1'($urandom_range(0, 1));
            ex_memread = 1'($urandom_range(0, 1));
            ex_wen = 1'($urandom_range(0, 3) != 0);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            if (m_streak > 0) begin
                mem_req = 1;
                mem_ready = ($urandom_range(0, 3) == 0);
            end else begin
                mem_req = ($urandom_range(0, 3) == 0);
                mem_ready = 1'($urandom_range(0, 1));
            end
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
